// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives a req/ready imem port and feeds decode
// through a registered output with a one-entry skid buffer. Optional macro: FETCH_JAL_PREDECODE_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] RD_Instr,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_kill_addr;
  logic [31:0] r_rd_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_skid_valid;

  logic        w_req;
  logic        w_done;
  logic        w_can_adv;
  logic [31:0] w_pc_next;

  assign w_req     = (r_state == S_REQ && !r_skid_valid) || (r_state == S_KILL);
  // Only a completion in REQ delivers data; KILL completions are thrown away.
  assign w_done    = w_req && imem_ready && (r_state == S_REQ);
  assign w_can_adv = !stall || !r_valid;

`ifdef FETCH_JAL_PREDECODE_EN
  logic [31:0] w_jal_imm;
  assign w_jal_imm = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                      imem_rdata[30:21], 1'b0};
  assign w_pc_next = (imem_rdata[6:0] == 7'b1101111) ? r_pc + w_jal_imm : r_pc + 32'd4;
`else
  assign w_pc_next = r_pc + 32'd4;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   if (redirect && w_req && !imem_ready) w_state_next = S_KILL;
      S_KILL:  if (imem_ready) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // KILL keeps presenting the abandoned address until memory completes it.
  always_comb begin
    imem_req  = w_req;
    imem_addr = (r_state == S_KILL) ? r_kill_addr : r_pc;
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_kill_addr  <= RESET_PC;
      r_rd_instr   <= NOP_INSTR;
      r_pc_out     <= '0;
      r_valid      <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else if (redirect) begin
      r_pc         <= redirect_pc;
      if (r_state == S_REQ) r_kill_addr <= r_pc;
      r_rd_instr   <= NOP_INSTR;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_done) r_pc <= w_pc_next;
      if (r_skid_valid && w_can_adv) begin
        r_rd_instr   <= r_skid_instr;
        r_pc_out     <= r_skid_pc;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_done && w_can_adv) begin
        r_rd_instr <= imem_rdata;
        r_pc_out   <= r_pc;
        r_valid    <= 1'b1;
      end else if (w_done) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_pc;
        r_skid_valid <= 1'b1;
      end else if (w_can_adv) begin
        r_rd_instr <= NOP_INSTR;
        r_valid    <= 1'b0;
      end
    end
  end

  assign RD_Instr    = r_rd_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/ready/redirect
// traffic, with a queue of expected {pc, instr} consumed by an independent monitor.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JAL_40   = 32'h0400_00EF;  // jal x1, +0x40

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] rd_instr;
  logic [31:0] pc_out;
  logic        instr_valid;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          consumed = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] kill_addr;

  fetch_stage dut (
    .clk1        (clk1),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .RD_Instr    (rd_instr),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  always #5 clk1 = ~clk1;

  // Program image: a JAL at 0x10, every other word is its own address + 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? JAL_40 : a + 32'h100;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
`ifdef FETCH_JAL_PREDECODE_EN
    if (w[6:0] == 7'b1101111)
      return pc + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
`endif
    return pc + 32'd4;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = next_pc(model_pc);
    end
  endtask

  task automatic start_segment(input logic [31:0] pc);
    exp_q.delete();
    model_pc = pc;
    top_up();
  endtask

  // Drive inputs for the next rising edge; expectations are queued at issue time.
  task automatic drive(input logic st, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk1);
    #1;
    stall       = st;
    imem_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    if (rd) start_segment(rpc);
    top_up();
  endtask

  task automatic peek();
    #2;
  endtask

  task automatic reset_pulse();
    @(negedge clk1);
    #1;
    rst = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk1);
    #1;
    rst = 1'b1;
    start_segment(RESET_PC);
  endtask

  // Monitor: snapshot just before each rising edge, compare against the queue.
  logic        p_ok = 1'b0;
  logic        p_stall, p_redirect, p_req, p_ready, p_valid;
  logic [31:0] p_addr, p_rd, p_pc;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk1);
      #3;
      if (!rst) begin
        p_ok = 1'b0;
      end else begin
        if (!instr_valid) check("nop_when_invalid", rd_instr, NOP);
        if (p_ok && p_stall && !p_redirect && p_valid) begin
          check("stall_hold_instr", rd_instr, p_rd);
          check("stall_hold_pc", pc_out, p_pc);
          check("stall_hold_valid", 32'(instr_valid), 32'd1);
        end
        if (p_ok && p_req && !p_ready) begin
          check("req_stable", 32'(imem_req), 32'd1);
          check("addr_stable", imem_addr, p_addr);
        end
        if (instr_valid && !stall && !redirect) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", pc_out, e.pc);
            check("out_instr", rd_instr, e.instr);
            consumed++;
          end
        end
        p_stall    = stall;
        p_redirect = redirect;
        p_req      = imem_req;
        p_ready    = imem_ready;
        p_valid    = instr_valid;
        p_addr     = imem_addr;
        p_rd       = rd_instr;
        p_pc       = pc_out;
        p_ok       = 1'b1;
      end
    end
  end

  initial begin
    logic        st, rdy, rd;
    logic [31:0] tgt;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    #2 rst = 1'b0;
    #11;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", rd_instr, NOP);
    check("rst_pc_out", pc_out, 32'd0);

    // Release reset, zero-wait streaming.
    @(negedge clk1);
    #1;
    rst = 1'b1;
    start_segment(RESET_PC);
    peek(); check("idle_req_low", 32'(imem_req), 32'd0);
    drive(0, 1, 0, 0); peek();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    drive(0, 1, 0, 0); peek();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_pc_out", pc_out, 32'h0);
    check("first_instr", rd_instr, 32'h100);
    check("addr_4", imem_addr, 32'h4);
    drive(0, 1, 0, 0); peek();
    check("addr_8", imem_addr, 32'h8);

    // Stall for three cycles while streaming: 0x8 held, 0xC parked in the skid.
    drive(1, 1, 0, 0); peek();
    check("stall_out_8", pc_out, 32'h8);
    check("stall_addr_c", imem_addr, 32'hC);
    drive(1, 1, 0, 0); peek();
    check("skid_req_low_a", 32'(imem_req), 32'd0);
    drive(1, 1, 0, 0); peek();
    check("skid_req_low_b", 32'(imem_req), 32'd0);
    check("skid_hold_8", pc_out, 32'h8);
    drive(0, 1, 0, 0); peek();
    check("skid_req_low_c", 32'(imem_req), 32'd0);
    drive(0, 1, 0, 0); peek();
    check("drain_pc_c", pc_out, 32'hC);
    check("drain_next_addr", imem_addr, 32'h10);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    // Slow memory with a redirect in the second wait cycle.
    drive(0, 0, 0, 0); peek();
    check("wait_req", 32'(imem_req), 32'd1);
    kill_addr = imem_addr;
    drive(0, 0, 1, 32'h200); peek();
    drive(0, 0, 0, 0); peek();
    check("kill_addr_held", imem_addr, kill_addr);
    check("kill_valid", 32'(instr_valid), 32'd0);
    drive(0, 1, 0, 0); peek();
    check("kill_req", 32'(imem_req), 32'd1);
    drive(0, 1, 0, 0); peek();
    check("redir_addr_200", imem_addr, 32'h200);
    drive(0, 1, 0, 0); peek();
    check("redir_pc_out_200", pc_out, 32'h200);
    check("redir_valid_200", 32'(instr_valid), 32'd1);
    drive(0, 1, 0, 0);

    // Redirect together with ready and stall.
    drive(1, 1, 1, 32'h300); peek();
    check("pre_redir_valid", 32'(instr_valid), 32'd1);
    drive(0, 1, 0, 0); peek();
    check("redir_nop", rd_instr, NOP);
    check("redir_invalid", 32'(instr_valid), 32'd0);
    check("redir_skid_empty", 32'(imem_req), 32'd1);
    check("redir_addr_300", imem_addr, 32'h300);

    // PC wrap-around.
    drive(0, 1, 1, 32'hFFFF_FFF8);
    drive(0, 1, 0, 0); peek(); check("wrap_fff8", imem_addr, 32'hFFFF_FFF8);
    drive(0, 1, 0, 0); peek(); check("wrap_fffc", imem_addr, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0); peek(); check("wrap_zero", imem_addr, 32'h0);

    // JAL at 0x10.
    drive(0, 1, 1, 32'h8);
    drive(0, 1, 0, 0); peek(); check("jal_addr_8", imem_addr, 32'h8);
    drive(0, 1, 0, 0); peek(); check("jal_addr_c", imem_addr, 32'hC);
    drive(0, 1, 0, 0); peek(); check("jal_addr_10", imem_addr, 32'h10);
    drive(0, 1, 0, 0); peek();
`ifdef FETCH_JAL_PREDECODE_EN
    check("jal_next", imem_addr, 32'h50);
`else
    check("jal_next", imem_addr, 32'h14);
`endif

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) reset_pulse();
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0;
        1:       tgt = 32'h4;
        2:       tgt = 32'($urandom) & 32'hFFFF_FFFC;
        default: tgt = 32'h100;
      endcase
      drive(st, rdy, rd, tgt);
    end
    repeat (10) drive(0, 1, 0, 0);
    check("consumed_enough", 32'(consumed > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
